axis_frame_fifo: RTL
====================

# axis_frame_fifo

Parametrised single-clock AXI-Stream FIFO: the next generation of our stream FIFO, generalised in data width and depth. It adds a store-and-forward frame mode, dropping of bad or oversized frames, and status outputs. It sits between a stream producer and consumer in the same clock domain, replacing the fixed 8-bit wrapper FIFO wherever frame integrity or fill-level visibility is needed.

## Interface
- DATA_WIDTH, 8, tdata width in bits (≥1)
- ADDR_WIDTH, 6, RAM address bits; RAM depth = 2^ADDR_WIDTH words
- FRAME_MODE, 0, 0 = cut-through (word visible once written), 1 = store-and-forward (frame visible only after its tlast is accepted)
- DROP_BAD_FRAME, 0, FRAME_MODE=1 only: discard a frame whose tlast word carries tuser=1
- DROP_WHEN_FULL, 0, FRAME_MODE=1 only: keep tready=1 while full and discard the incoming frame

- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- input_axis_tdata  in  DATA_WIDTH  write data
- input_axis_tvalid  in  1  write valid
- input_axis_tready  out  1  write ready
- input_axis_tlast  in  1  end of frame
- input_axis_tuser  in  1  bad-frame marker, meaningful with tlast
- output_axis_tdata  out  DATA_WIDTH  read data, registered
- output_axis_tvalid  out  1  read valid, registered
- output_axis_tready  in  1  read ready
- output_axis_tlast  out  1  end of frame
- output_axis_tuser  out  1  user bit passed through
- status_overflow  out  1  1-cycle pulse when a frame is dropped for lack of space
- status_bad_frame  out  1  1-cycle pulse when a frame is dropped for tuser
- status_good_frame  out  1  1-cycle pulse when a frame is committed (FRAME_MODE=1)
- status_level  out  ADDR_WIDTH+1  committed words held in RAM (output register excluded)

## Operation
- Storage: RAM of 2^ADDR_WIDTH × (DATA_WIDTH+2) holding {tlast, tuser, tdata}, plus one output register.
- Pointers are ADDR_WIDTH+1 bits, wrapping modulo 2^(ADDR_WIDTH+1).
- Empty: wr_ptr == rd_ptr.
- Full: MSBs differ and the low bits are equal.
- Write pointers: wr_ptr_cur advances on every accepted word. wr_ptr is the committed pointer.
  - FRAME_MODE=0: wr_ptr follows wr_ptr_cur each accepted word.
  - FRAME_MODE=1: wr_ptr ← wr_ptr_cur+1 only when the tlast word is accepted with no drop pending.
- input_axis_tready = !rst && (!full_cur || drop_frame || (FRAME_MODE && DROP_WHEN_FULL)). Here full_cur compares wr_ptr_cur with rd_ptr.
- Drop (FRAME_MODE=1 only):
  - drop_frame is set when a word arrives while full_cur. This happens either with DROP_WHEN_FULL=1, or when the frame has already filled the RAM (wr_ptr_cur − wr_ptr == 2^ADDR_WIDTH).
  - While drop_frame is set, words are accepted and discarded, and wr_ptr_cur ← wr_ptr.
  - On tlast: drop_frame clears and status_overflow pulses.
  - A bad frame (tlast with tuser=1 and DROP_BAD_FRAME=1) rewinds wr_ptr_cur ← wr_ptr and pulses status_bad_frame; status_good_frame does not pulse.
  - Overflow and bad-frame conditions on the same tlast pulse status_overflow only.
- Read side: the output register loads RAM[rd_ptr] and rd_ptr increments when RAM is non-empty and (!output_axis_tvalid || output_axis_tready). output_axis_tvalid clears when the consumer takes the word and RAM is empty.
- Simultaneous write and read of the same entry: the read sees the committed pointer only, so there is no hazard.
- Reset values: all pointers 0, drop_frame 0, output_axis_tvalid 0, tdata/tlast/tuser 0, input_axis_tready 0 while rst=1, status pulses 0, status_level 0.
- Reset mid-frame or mid-output discards everything, including the partial frame and the output register. Words presented while rst=1 are never accepted.

## Timing
- Cut-through latency: word accepted at edge k gives output_axis_tvalid high after edge k+1.
- Frame mode latency: the first word of a frame is visible after edge k+1, where k is its tlast acceptance edge.
- Throughput: one word per cycle each side, sustained.
- Capacity: 2^ADDR_WIDTH + 1 words with the consumer stalled (RAM plus output register).
- Status pulses assert the cycle after the causing tlast edge. status_level is registered and updates one cycle after the pointer change.
- tready is combinational from registered state and rst. There is no path from output_axis_tready to input_axis_tready.

## Test plan
- Reset stall: rst=1 for cycles 0–3 with tvalid=1, tdata=0x01 → tready=0 throughout. After release, the first output word is 0x01 and no pre-reset word appears.
- Cut-through, DATA_WIDTH=8, ADDR_WIDTH=2: stream 0x01..0x0A with output_axis_tready=1 → output 0x01..0x0A in order, first tvalid one cycle after the first accept, no bubbles.
- Full: ADDR_WIDTH=2, output_axis_tready=0, offer 8 words → exactly 5 accepted and then tready=0, status_level=4. Draining yields 0x01..0x05.
- Bad frame: FRAME_MODE=1, DROP_BAD_FRAME=1. Send 3-word frame 0x20–0x22 with tuser=1 on tlast, then frame 0x10,0x11 → status_bad_frame pulses once, output is only 0x10,0x11 with tlast on 0x11, status_good_frame pulses once.
- Oversize: FRAME_MODE=1, ADDR_WIDTH=2, send a 6-word frame → tready stays 1, status_overflow pulses at tlast, nothing is output, status_level=0.
- Reset mid-output: with 3 words buffered and tvalid=1, assert rst for one cycle → tvalid=0 the next cycle, status_level=0, and subsequent traffic is clean.

Source files
------------

// File: rtl/axis_frame_fifo.sv
// -----------------------------------------------------------------------------
// axis_frame_fifo
//
// Single-clock AXI-Stream FIFO with an optional store-and-forward frame mode.
// Words are kept in a RAM of 2^ADDR_WIDTH entries holding {tlast, tuser, tdata}
// and are presented to the consumer through one output register.
//
// In cut-through mode (FRAME_MODE=0) a word is readable as soon as it is
// written. In frame mode (FRAME_MODE=1) words are written ahead of a committed
// pointer and become readable only once the frame's tlast word is accepted.
// Frame mode can also discard bad frames (tuser on the tlast word) and frames
// that cannot fit.
//
// Ports
//   clk, rst                 sole clock; synchronous active-high reset
//   input_axis_*             write side (tdata, tvalid, tready, tlast, tuser)
//   output_axis_*            read side, registered (tdata, tvalid, tready,
//                            tlast, tuser)
//   status_overflow          1-cycle pulse: frame dropped for lack of space
//   status_bad_frame         1-cycle pulse: frame dropped for tuser
//   status_good_frame        1-cycle pulse: frame committed (frame mode)
//   status_level             committed words in RAM (output register excluded)
// -----------------------------------------------------------------------------
module axis_frame_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter bit FRAME_MODE     = 1'b0,
  parameter bit DROP_BAD_FRAME = 1'b0,
  parameter bit DROP_WHEN_FULL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,

  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,

  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame,
  output logic [ADDR_WIDTH:0]   status_level
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int WORD_WIDTH = DATA_WIDTH + 2;

  localparam logic [ADDR_WIDTH:0] PTR_ZERO   = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  // Pointer distance that means "the whole RAM"
  localparam logic [ADDR_WIDTH:0] PTR_SPAN   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  // Write-side frame state: passing words into RAM, or discarding a frame
  typedef enum logic [0:0] {
    WR_PASS = 1'b0,
    WR_DROP = 1'b1
  } wr_state_t;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr;       // committed write pointer (readable limit)
  logic [ADDR_WIDTH:0] wr_ptr_cur;   // speculative write pointer
  logic [ADDR_WIDTH:0] rd_ptr;

  wr_state_t           wr_state;
  wr_state_t           wr_state_next;

  logic                full_cur;
  logic                empty;
  logic                accept;
  logic                read_en;
  logic                drop_frame;
  logic                frame_fill;
  logic [ADDR_WIDTH:0] wr_ptr_cur_inc;
  logic [ADDR_WIDTH:0] frame_words;

  logic                mem_we;
  logic [ADDR_WIDTH:0] wr_ptr_next;
  logic [ADDR_WIDTH:0] wr_ptr_cur_next;
  logic                overflow_next;
  logic                bad_frame_next;
  logic                good_frame_next;

  assign drop_frame     = (wr_state == WR_DROP);
  assign wr_ptr_cur_inc = wr_ptr_cur + PTR_ONE;
  assign frame_words    = wr_ptr_cur_inc - wr_ptr;

  // RAM is full from the writer's view once the speculative pointer laps rd_ptr
  assign full_cur = (wr_ptr_cur[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr_cur[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  // The reader only ever sees committed words
  assign empty = (wr_ptr == rd_ptr);

  // A non-tlast word that brings the open frame to a full RAM proves the frame
  // can never fit, so the drop starts right away and the writer never stalls.
  assign frame_fill = (frame_words == PTR_SPAN);

  assign input_axis_tready = !rst &&
                             (!full_cur || drop_frame || (FRAME_MODE && DROP_WHEN_FULL));
  assign accept  = input_axis_tvalid && input_axis_tready;
  assign read_en = !empty && (!output_axis_tvalid || output_axis_tready);

  // Write-side state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_PASS;
    end else begin
      wr_state <= wr_state_next;
    end
  end

  // Write-side next state: enter drop on overflow, leave on the frame's tlast
  always_comb begin
    wr_state_next = wr_state;
    if (FRAME_MODE && accept) begin
      case (wr_state)
        WR_PASS: begin
          if (full_cur) begin
            wr_state_next = input_axis_tlast ? WR_PASS : WR_DROP;
          end else if (!input_axis_tlast && frame_fill) begin
            wr_state_next = WR_DROP;
          end else begin
            wr_state_next = WR_PASS;
          end
        end
        WR_DROP: begin
          if (input_axis_tlast) begin
            wr_state_next = WR_PASS;
          end else begin
            wr_state_next = WR_DROP;
          end
        end
        default: wr_state_next = WR_PASS;
      endcase
    end else begin
      wr_state_next = wr_state;
    end
  end

  // Write-side outputs: RAM write enable, pointer updates and status pulses
  always_comb begin
    mem_we          = 1'b0;
    wr_ptr_next     = wr_ptr;
    wr_ptr_cur_next = wr_ptr_cur;
    overflow_next   = 1'b0;
    bad_frame_next  = 1'b0;
    good_frame_next = 1'b0;
    if (accept && !FRAME_MODE) begin
      mem_we          = 1'b1;
      wr_ptr_cur_next = wr_ptr_cur_inc;
      wr_ptr_next     = wr_ptr_cur_inc;
    end else if (accept) begin
      case (wr_state)
        WR_PASS: begin
          if (full_cur) begin
            // Only reachable with DROP_WHEN_FULL: discard this word and frame
            wr_ptr_cur_next = wr_ptr;
            overflow_next   = input_axis_tlast;
          end else begin
            mem_we = 1'b1;
            if (input_axis_tlast && DROP_BAD_FRAME && input_axis_tuser) begin
              wr_ptr_cur_next = wr_ptr;
              bad_frame_next  = 1'b1;
            end else if (input_axis_tlast) begin
              wr_ptr_cur_next = wr_ptr_cur_inc;
              wr_ptr_next     = wr_ptr_cur_inc;
              good_frame_next = 1'b1;
            end else if (frame_fill) begin
              wr_ptr_cur_next = wr_ptr;
            end else begin
              wr_ptr_cur_next = wr_ptr_cur_inc;
            end
          end
        end
        WR_DROP: begin
          // Overflow wins over a bad-frame marker on the same tlast
          wr_ptr_cur_next = wr_ptr;
          overflow_next   = input_axis_tlast;
        end
        default: begin
          wr_ptr_cur_next = wr_ptr;
        end
      endcase
    end else begin
      mem_we          = 1'b0;
      wr_ptr_next     = wr_ptr;
      wr_ptr_cur_next = wr_ptr_cur;
    end
  end

  // Write pointers and status pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr            <= PTR_ZERO;
      wr_ptr_cur        <= PTR_ZERO;
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      wr_ptr            <= wr_ptr_next;
      wr_ptr_cur        <= wr_ptr_cur_next;
      status_overflow   <= overflow_next;
      status_bad_frame  <= bad_frame_next;
      status_good_frame <= good_frame_next;
    end
  end

  // RAM write port; contents need no reset because the pointers gate reads
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= {input_axis_tlast, input_axis_tuser, input_axis_tdata};
    end
  end

  // Output register: refills from RAM whenever it is empty or being consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr             <= PTR_ZERO;
      output_axis_tvalid <= 1'b0;
      output_axis_tdata  <= DATA_ZERO;
      output_axis_tlast  <= 1'b0;
      output_axis_tuser  <= 1'b0;
    end else if (read_en) begin
      rd_ptr             <= rd_ptr + PTR_ONE;
      output_axis_tvalid <= 1'b1;
      {output_axis_tlast, output_axis_tuser, output_axis_tdata} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end else if (output_axis_tready) begin
      output_axis_tvalid <= 1'b0;
    end else begin
      output_axis_tvalid <= output_axis_tvalid;
    end
  end

  // Committed fill level, registered from the current pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      status_level <= PTR_ZERO;
    end else begin
      status_level <= wr_ptr - rd_ptr;
    end
  end

endmodule
